segment_scan_controller: RTL and testbench

Time-multiplexes NUM_DIGITS packed 4-bit digit values onto one shared 7-segment bus with one-hot digit enables. Each digit is driven for a dwell period, then a blanking gap follows to suppress ghosting. New display values arrive through a valid/ready handshake and are committed only at a frame boundary, so a frame never shows a torn value. Sits between application logic and the board's common-anode/cathode digit drivers.

---
 rtl/segment_pkg.sv | 45 ++++
 rtl/segment_scan_timer.sv | 36 +++
 rtl/segment_scan_controller.sv | 173 +++++++++++++++++
 tb/tb_segment_scan_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_pkg.sv
// Shared seven-segment types and decode helpers (segment bit order {g,f,e,d,c,b,a}).
// The scan controller's optional leading-zero blanking is selected by SEGMENT_LEADING_ZERO_BLANK_EN.
package segment_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_DRIVE = 2'd1,
    SCAN_BLANK = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [6:0] int_base16_to_segment(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Non-decimal codes render dark rather than as letters.
  function automatic logic [6:0] int_base10_to_segment(input logic [3:0] value);
    return (value > 4'd9) ? SEG_BLANK : int_base16_to_segment(value);
  endfunction

endpackage

// File: rtl/segment_scan_timer.sv
// Loadable down-counter that times the dwell and blanking phases of the scan.
// zero is asserted while the count sits at 0; load takes priority over counting.
module segment_scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  assign zero = (count_q == '0);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/segment_scan_controller.sv
// Multiplexes packed 4-bit digits onto a shared 7-segment bus with blanking gaps and
// frame-aligned value commits. Define SEGMENT_LEADING_ZERO_BLANK_EN to blank leading zeros.
module segment_scan_controller
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter bit BASE_10      = 1'b1,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [6:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_full_q, pending_full_d;
  logic                    wrap_q, wrap_d;
  logic [6:0]              segment_q, segment_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_load_value;
  logic             timer_zero;
  logic             commit_now;
  logic             transfer;
  logic [3:0]       cur_digit;
  logic [6:0]       decoded;
  logic             suppress;

  segment_scan_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .zero       (timer_zero)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    timer_load       = 1'b0;
    timer_load_value = DWELL_LOAD;
    wrap_d           = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        if (enable) begin
          state_d    = SCAN_DRIVE;
          idx_d      = '0;
          timer_load = 1'b1;
        end
      end
      SCAN_DRIVE: begin
        if (!enable) begin
          state_d = SCAN_IDLE;
          idx_d   = '0;
        end else if (timer_zero) begin
          state_d          = SCAN_BLANK;
          timer_load       = 1'b1;
          timer_load_value = BLANK_LOAD;
        end
      end
      SCAN_BLANK: begin
        if (!enable) begin
          state_d = SCAN_IDLE;
          idx_d   = '0;
        end else if (timer_zero) begin
          state_d    = SCAN_DRIVE;
          timer_load = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = SCAN_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // New values only reach the display on entry to digit 0, so a frame is never torn.
  always_comb begin
    commit_now     = (state_d == SCAN_DRIVE) && (state_q != SCAN_DRIVE) &&
                     (idx_d == '0) && pending_full_q;
    value_ready    = !pending_full_q || commit_now;
    transfer       = value_valid && value_ready;
    active_d       = commit_now ? pending_q : active_q;
    pending_d      = transfer ? value_in : pending_q;
    pending_full_d = transfer ? 1'b1 : (commit_now ? 1'b0 : pending_full_q);
  end

`ifdef SEGMENT_LEADING_ZERO_BLANK_EN
  logic upper_nonzero;

  always_comb begin
    upper_nonzero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (active_q[4*i +: 4] != 4'd0)) begin
        upper_nonzero = 1'b1;
      end
    end
    suppress = (idx_q != '0) && !upper_nonzero;
  end
`else
  assign suppress = 1'b0;
`endif

  // Outputs follow the state register by one cycle so segment and digit_en never skew.
  always_comb begin
    cur_digit    = active_q[{idx_q, 2'b00} +: 4];
    decoded      = BASE_10 ? int_base10_to_segment(cur_digit) : int_base16_to_segment(cur_digit);
    segment_d    = SEG_BLANK;
    digit_en_d   = '0;
    frame_done_d = wrap_q;
    if (state_q == SCAN_DRIVE) begin
      digit_en_d = NUM_DIGITS'(1) << idx_q;
      segment_d  = suppress ? SEG_BLANK : decoded;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SCAN_IDLE;
      idx_q          <= '0;
      // NOTE: the value registers are reset because a reset must discard the pending value.
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      wrap_q         <= 1'b0;
      segment_q      <= SEG_BLANK;
      digit_en_q     <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      wrap_q         <= wrap_d;
      segment_q      <= segment_d;
      digit_en_q     <= digit_en_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign segment    = segment_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_segment_scan_controller.sv
// Bench for segment_scan_controller: decimal and hex instances share stimulus and are
// compared every cycle against a frame-timeline model, plus directed literal expectations.
module tb_segment_scan_controller;

  localparam int N     = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int P     = DWELL + BLANK;
  localparam int FRAME = P * N;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value_in;
  logic        value_valid;

  logic        value_ready, frame_done;
  logic [6:0]  segment;
  logic [3:0]  digit_en;
  logic        value_ready_hex, frame_done_hex;
  logic [6:0]  segment_hex;
  logic [3:0]  digit_en_hex;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  segment_scan_controller #(
    .NUM_DIGITS(N), .BASE_10(1'b1), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .value_in(value_in),
    .value_valid(value_valid), .value_ready(value_ready), .segment(segment),
    .digit_en(digit_en), .frame_done(frame_done)
  );

  segment_scan_controller #(
    .NUM_DIGITS(N), .BASE_10(1'b0), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
  ) dut_hex (
    .clk(clk), .reset(reset), .enable(enable), .value_in(value_in),
    .value_valid(value_valid), .value_ready(value_ready_hex), .segment(segment_hex),
    .digit_en(digit_en_hex), .frame_done(frame_done_hex)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  bit          m_valid = 1'b0;
  bit          m_run   = 1'b0;
  int          m_t     = 0;
  logic [15:0] m_active  = '0;
  logic [15:0] m_pending = '0;
  bit          m_full  = 1'b0;
  logic [6:0]  e_seg = '0, e_seg_hex = '0;
  logic [3:0]  e_en = '0;
  bit          e_fd = 1'b0;

  function automatic logic [6:0] model_seg(input int idx, input logic [15:0] act, input bit dec);
    logic [15:0] upper;
    logic [3:0]  d;
    upper = act >> (4 * idx);
    d     = upper[3:0];
`ifdef SEGMENT_LEADING_ZERO_BLANK_EN
    if (idx > 0 && upper == 16'd0) return 7'h00;
`endif
    if (dec && d > 4'd9) return 7'h00;
    return seg_table[d];
  endfunction

  // True when the coming edge starts a new frame at digit 0.
  function automatic bit frame_start_next(input logic en, input bit run, input int t);
    return en && (!run || ((t + 1) % FRAME == 0));
  endfunction

  always @(posedge clk) begin
    bit fs, xfer;
    int idx;
    if (reset) begin
      m_valid = 1'b1; m_run = 1'b0; m_t = 0;
      m_active = '0; m_pending = '0; m_full = 1'b0;
      e_seg = '0; e_seg_hex = '0; e_en = '0; e_fd = 1'b0;
    end else begin
      e_fd = m_run && (m_t > 0) && (m_t % FRAME == 0);
      if (m_run && (m_t % P) < DWELL) begin
        idx       = (m_t / P) % N;
        e_en      = 4'(1 << idx);
        e_seg     = model_seg(idx, m_active, 1'b1);
        e_seg_hex = model_seg(idx, m_active, 1'b0);
      end else begin
        e_en = '0; e_seg = '0; e_seg_hex = '0;
      end
      fs   = frame_start_next(enable, m_run, m_t);
      xfer = value_valid && (!m_full || fs);
      if (fs && m_full) begin
        m_active = m_pending;
        m_full   = 1'b0;
      end
      if (xfer) begin
        m_pending = value_in;
        m_full    = 1'b1;
      end
      if (enable) begin
        m_t   = m_run ? m_t + 1 : 0;
        m_run = 1'b1;
      end else begin
        m_run = 1'b0;
        m_t   = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit e_rdy;
    if (m_valid) begin
      e_rdy = !m_full || frame_start_next(enable, m_run, m_t);
      check("segment",        segment,         e_seg);
      check("digit_en",       digit_en,        e_en);
      check("frame_done",     frame_done,      e_fd);
      check("value_ready",    value_ready,     e_rdy);
      check("hex_segment",    segment_hex,     e_seg_hex);
      check("hex_digit_en",   digit_en_hex,    e_en);
      check("hex_frame_done", frame_done_hex,  e_fd);
      check("hex_value_ready", value_ready_hex, e_rdy);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_digit(input logic [3:0] mask, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (digit_en === mask) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1);
    #1;
  endtask

  task automatic wait_frame_done(input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1);
    #1;
  endtask

  task automatic offer_held(input logic [15:0] v, input int budget, input string name);
    bit accepted = 1'b0;
    value_in    = v;
    value_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (value_ready) begin
        tick(1);
        accepted = 1'b1;
        break;
      end
      tick(1);
    end
    value_valid = 1'b0;
    check(name, accepted, 1);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; enable = 1'b0; value_in = '0; value_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    check("rst_segment", segment, 7'h00);
    check("rst_digit_en", digit_en, 4'h0);
    check("rst_ready", value_ready, 1);
    check("rst_frame_done", frame_done, 0);

    // 1: load 1234 while idle, then scan one full frame
    value_in = 16'h1234; value_valid = 1'b1;
    tick(1);
    value_valid = 1'b0;
    check("t1_ready_low", value_ready, 0);
    enable = 1'b1;
    #1;
    check("t1_ready_commit", value_ready, 1);
    wait_digit(4'b0001, 5, "t1_wait_d0");
    check("t1_d0_seg", segment, 7'h66);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_done === 1'b1) break;
    end
    check("t1_frame_len", cnt, 24);
    #1;
    check("t1_wrap_d0", digit_en, 4'b0001);

    // 2: new value mid-frame waits for the frame boundary; a held second offer lands at commit
    wait_digit(4'b0100, 30, "t2_wait_d2");
    value_in = 16'h5678; value_valid = 1'b1;
    tick(1);
    check("t2_ready_low", value_ready, 0);
    offer_held(16'h4321, 40, "t2_second_accept");
    wait_digit(4'b0001, 5, "t2_wait_d0");
    check("t2_d0_seg", segment, 7'h7F);
    check("t2_frame_done", frame_done, 1);

    // 3: digit value A in decimal and hex
    offer_held(16'h12A5, 40, "t3_accept");
    wait_frame_done(40, "t3_fd_a");
    wait_frame_done(40, "t3_fd_b");
    wait_digit(4'b0010, 10, "t3_wait_d1");
    check("t3_dec_A", segment, 7'h00);
    check("t3_hex_A", segment_hex, 7'h77);

    // 4: drop enable mid-drive of digit 2, then restart
    wait_digit(4'b0100, 30, "t4_wait_d2");
    enable = 1'b0;
    tick(2);
    check("t4_dark_en", digit_en, 4'h0);
    check("t4_dark_seg", segment, 7'h00);
    tick(3);
    enable = 1'b1;
    wait_digit(4'b0001, 10, "t4_restart_d0");
    check("t4_restart_seg", segment, 7'h6D);

    // 5: reset during blank with pending full
    value_in = 16'h8888; value_valid = 1'b1;
    tick(1);
    value_valid = 1'b0;
    wait_digit(4'b0010, 20, "t5_wait_d1");
    wait_digit(4'b0000, 10, "t5_wait_blank");
    reset = 1'b1;
    tick(1);
    check("t5_rst_seg", segment, 7'h00);
    check("t5_rst_en", digit_en, 4'h0);
    check("t5_rst_ready", value_ready, 1);
    check("t5_rst_fd", frame_done, 0);
    reset = 1'b0;
    wait_digit(4'b0001, 10, "t5_wait_d0");
    check("t5_zero_seg", segment, 7'h3F);

    // 6: leading-zero behaviour on 0070
    value_in = 16'h0070; value_valid = 1'b1;
    tick(1);
    value_valid = 1'b0;
    wait_frame_done(40, "t6_fd");
    check("t6_d0_seg", segment, 7'h3F);
    wait_digit(4'b0010, 10, "t6_wait_d1");
    check("t6_d1_seg", segment, 7'h07);
    wait_digit(4'b0100, 10, "t6_wait_d2");
`ifdef SEGMENT_LEADING_ZERO_BLANK_EN
    check("t6_d2_seg", segment, 7'h00);
`else
    check("t6_d2_seg", segment, 7'h3F);
`endif
    wait_digit(4'b1000, 10, "t6_wait_d3");
`ifdef SEGMENT_LEADING_ZERO_BLANK_EN
    check("t6_d3_seg", segment, 7'h00);
`else
    check("t6_d3_seg", segment, 7'h3F);
`endif

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
